// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: access-size codes,
// FSM state encoding and the load-data sign/zero extension helper.
package mau_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      RESP = 2'd3
   } mau_state_e;

   // Bytes above the access size are already zero in value; only the sign fill is decided here.
   function automatic logic [31:0] mau_extend(input logic [31:0] value,
                                               input logic [1:0]  size,
                                               input logic        is_unsigned);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        res;
      b = $signed(value[7:0]);
      h = $signed(value[15:0]);
      case (size)
         SZ_BYTE: res = is_unsigned ? {24'b0, value[7:0]}  : 32'(b);
         SZ_HALF: res = is_unsigned ? {16'b0, value[15:0]} : 32'(h);
         default: res = value;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane steering: byte mask and store data over two adjacent
// words, and right-justified load bytes gathered from the lo/hi buffers.
module mau_lane_align
   import mau_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] lo_i,
   input  logic [31:0] hi_i,
   output logic [7:0]  m8_o,
   output logic [63:0] d64_o,
   output logic [31:0] ldata_o
);

   logic [7:0]  base_mask;
   logic [31:0] size_mask;

   always_comb begin
      base_mask = 8'h0F;
      size_mask = 32'hFFFF_FFFF;
      case (size_i)
         SZ_BYTE: begin
            base_mask = 8'h01;
            size_mask = 32'h0000_00FF;
         end
         SZ_HALF: begin
            base_mask = 8'h03;
            size_mask = 32'h0000_FFFF;
         end
         default: begin
            base_mask = 8'h0F;
            size_mask = 32'hFFFF_FFFF;
         end
      endcase
   end

   assign m8_o    = base_mask << off_i;
   assign d64_o   = {32'b0, wdata_i} << {off_i, 3'b000};
   assign ldata_o = 32'(({hi_i, lo_i} >> {off_i, 3'b000})) & size_mask;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a byte-enabled word RAM. Define MAU_MISALIGN_EN to run
// word-crossing accesses as two RAM cycles; without it misaligned requests are rejected.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  _rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  ram_w_en,
   output logic [3:0]            ram_sel,
   output logic [ADDR_WIDTH-1:0] ram_w_addr,
   output logic [31:0]           ram_wdata,
   output logic [ADDR_WIDTH-1:0] ram_r_addr,
   input  logic [31:0]           ram_rdata
);

   mau_state_e            state_q, state_d;
   logic                  we_q, uns_q, err_q;
   logic [1:0]            size_q;
   logic [ADDR_WIDTH+1:0] addr_q;
   logic [31:0]           wdata_q, lo_q;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]           ram_wdata_q, ram_wdata_d;

   logic [1:0]            off;
   logic [ADDR_WIDTH-1:0] word0;
   logic [7:0]            m8;
   logic [63:0]           d64;
   logic [31:0]           ldata, hi_buf;
   logic                  accept, req_bad;

   assign off    = addr_q[1:0];
   assign word0  = addr_q[ADDR_WIDTH+1:2];
   assign accept = req_valid && (state_q == IDLE);

`ifdef MAU_MISALIGN_EN
   logic [31:0]           hi_q;
   logic [ADDR_WIDTH-1:0] word1;
   logic                  split;

   assign word1   = word0 + ADDR_WIDTH'(1);
   assign split   = ((size_q == SZ_HALF) && (off == 2'd3)) ||
                    ((size_q == SZ_WORD) && (off != 2'd0));
   assign req_bad = (req_size == SZ_RSVD);
   assign hi_buf  = hi_q;

   // hi must read as zero for unsplit loads, so it is cleared on every accept.
   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         hi_q <= '0;
      end else if (accept) begin
         hi_q <= '0;
      end else if ((state_q == ACC1) && !we_q) begin
         hi_q <= ram_rdata;
      end
   end
`else
   logic req_misal;
   logic unused_hi_lanes;

   assign req_misal = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
   assign req_bad   = (req_size == SZ_RSVD) || req_misal;
   assign hi_buf    = 32'b0;
   // Aligned accesses never reach the upper word, so these lanes are dead here.
   assign unused_hi_lanes = ^{m8[7:4], d64[63:32]};
`endif

   mau_lane_align u_align (
      .off_i   (off),
      .size_i  (size_q),
      .wdata_i (wdata_q),
      .lo_i    (lo_q),
      .hi_i    (hi_buf),
      .m8_o    (m8),
      .d64_o   (d64),
      .ldata_o (ldata)
   );

   always_comb begin
      state_d     = state_q;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      ram_w_en    = 1'b0;
      ram_sel     = 4'b0000;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = req_bad ? RESP : ACC0;
            end
         end
         ACC0: begin
            ram_addr_d  = word0;
            ram_wdata_d = d64[31:0];
            ram_w_en    = we_q;
            ram_sel     = we_q ? m8[3:0] : 4'b0000;
`ifdef MAU_MISALIGN_EN
            state_d     = split ? ACC1 : RESP;
`else
            state_d     = RESP;
`endif
         end
`ifdef MAU_MISALIGN_EN
         ACC1: begin
            ram_addr_d  = word1;
            ram_wdata_d = d64[63:32];
            ram_w_en    = we_q;
            ram_sel     = we_q ? m8[7:4] : 4'b0000;
            state_d     = RESP;
         end
`endif
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         err_q       <= 1'b0;
         size_q      <= SZ_BYTE;
         addr_q      <= '0;
         wdata_q     <= '0;
         lo_q        <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            err_q   <= req_bad;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if ((state_q == ACC0) && !we_q) begin
            lo_q <= ram_rdata;
         end
      end
   end

   // RAM addresses and write data keep their last driven value outside ACC0/ACC1.
   assign ram_w_addr = ram_addr_d;
   assign ram_r_addr = ram_addr_d;
   assign ram_wdata  = ram_wdata_d;
   assign rsp_err    = (state_q == RESP) && err_q;
   assign rsp_rdata  = ((state_q == RESP) && !err_q && !we_q) ?
                       mau_extend(ldata, size_q, uns_q) : 32'b0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written corner sequences,
// and randomized traffic scored against a byte-level memory model.
`timescale 1ns/1ps
module tb_mem_access_unit;

   localparam int AW     = 10;
   localparam int NBYTES = 4 << AW;
`ifdef MAU_MISALIGN_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]    req_size;
   logic [AW+1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [31:0]   rsp_rdata;
   logic          ram_w_en;
   logic [3:0]    ram_sel;
   logic [AW-1:0] ram_w_addr, ram_r_addr;
   logic [31:0]   ram_wdata, ram_rdata;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      ._rst         (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .ram_w_en     (ram_w_en),
      .ram_sel      (ram_sel),
      .ram_w_addr   (ram_w_addr),
      .ram_wdata    (ram_wdata),
      .ram_r_addr   (ram_r_addr),
      .ram_rdata    (ram_rdata)
   );

   // Byte-enabled word RAM with combinational read.
   logic [31:0] ram [0:(1<<AW)-1];
   assign ram_rdata = ram[ram_r_addr];
   always @(posedge clk) begin
      if (ram_w_en)
         for (int b = 0; b < 4; b++)
            if (ram_sel[b]) ram[ram_w_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
   end

   // Byte-addressed reference memory.
   logic [7:0] ref_mem [0:NBYTES-1];

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
   endtask

   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW+1:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata,
                        output int lat, output int nwr);
      int n, o;
      longint v;
      n = 1 << size;
      o = int'(addr) % 4;
      err   = (size == 2'd3) || (!MIS && (o % n) != 0);
      rdata = 32'h0;
      lat   = 1;
      nwr   = 0;
      if (!err) begin
         lat = (o + n > 4) ? 3 : 2;
         if (we) begin
            nwr = (o + n > 4) ? 2 : 1;
            for (int i = 0; i < n; i++)
               ref_mem[(int'(addr) + i) % NBYTES] = wdata[8*i +: 8];
         end else begin
            v = 0;
            for (int i = 0; i < n; i++)
               v = v + (longint'(ref_mem[(int'(addr) + i) % NBYTES]) << (8*i));
            if (!uns && v >= (longint'(1) << (8*n-1)))
               v = v - (longint'(1) << (8*n));
            rdata = v[31:0];
         end
      end
   endtask

   logic [AW-1:0] wr_addr [2];
   logic [3:0]    wr_sel  [2];
   logic [31:0]   wr_data [2];

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [AW+1:0] addr, input logic [31:0] wdata,
                         output logic got, output logic err, output logic [31:0] rdata,
                         output int lat, output int nwr);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      got = 1'b0; err = 1'b0; rdata = 32'h0; lat = 0; nwr = 0;
      for (int k = 1; k <= 6 && !got; k++) begin
         if (rsp_valid) begin
            got = 1'b1; lat = k; err = rsp_err; rdata = rsp_rdata;
         end else begin
            if (ram_w_en) begin
               if (nwr < 2) begin
                  wr_addr[nwr] = ram_w_addr; wr_sel[nwr] = ram_sel; wr_data[nwr] = ram_wdata;
               end
               nwr++;
            end
            @(posedge clk); #1;
         end
      end
      if (got) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run_and_check(input string name, input logic we, input logic [1:0] size,
                                input logic uns, input logic [AW+1:0] addr, input logic [31:0] wdata,
                                input logic exp_err, input logic [31:0] exp_rdata,
                                input int exp_lat, input int exp_wr);
      logic got, err;
      logic [31:0] rdata;
      int lat, nwr;
      do_req(we, size, uns, addr, wdata, got, err, rdata, lat, nwr);
      chk({name, "_rsp_seen"}, 32'(got), 32'd1);
      chk({name, "_err"}, 32'(err), 32'(exp_err));
      chk({name, "_rdata"}, rdata, exp_rdata);
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({name, "_ram_writes"}, 32'(nwr), 32'(exp_wr));
   endtask

   task automatic model_and_run(input string name, input logic we, input logic [1:0] size,
                                input logic uns, input logic [AW+1:0] addr, input logic [31:0] wdata);
      logic e; logic [31:0] r; int l, w;
      model(we, size, uns, addr, wdata, e, r, l, w);
      run_and_check(name, we, size, uns, addr, wdata, e, r, l, w);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
      chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
      chk({tag, "_rsp_rdata"},  rsp_rdata,       32'd0);
      chk({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
      chk({tag, "_ram_w_en"},   32'(ram_w_en),   32'd0);
      chk({tag, "_ram_sel"},    32'(ram_sel),    32'd0);
      chk({tag, "_ram_w_addr"}, 32'(ram_w_addr), 32'd0);
      chk({tag, "_ram_r_addr"}, 32'(ram_r_addr), 32'd0);
      chk({tag, "_ram_wdata"},  ram_wdata,       32'd0);
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_wr;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic e; logic [31:0] r, exp_r; int l, w;
      logic [31:0] held;
      logic seen;

      vecs.push_back('{1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 32'h00000000, 2, 1});
      vecs.push_back('{1'b0, 2'd2, 1'b0, 12'h010, 32'h00000000, 1'b0, 32'hDEADBEEF, 2, 0});
      vecs.push_back('{1'b1, 2'd0, 1'b0, 12'h013, 32'h00000080, 1'b0, 32'h00000000, 2, 1});
      vecs.push_back('{1'b0, 2'd0, 1'b0, 12'h013, 32'h00000000, 1'b0, 32'hFFFFFF80, 2, 0});
      vecs.push_back('{1'b0, 2'd0, 1'b1, 12'h013, 32'h00000000, 1'b0, 32'h00000080, 2, 0});
      vecs.push_back('{1'b0, 2'd1, 1'b0, 12'h012, 32'h00000000, 1'b0, 32'hFFFF80AD, 2, 0});
      vecs.push_back('{1'b0, 2'd1, 1'b1, 12'h010, 32'h00000000, 1'b0, 32'h0000BEEF, 2, 0});
      vecs.push_back('{1'b1, 2'd3, 1'b0, 12'h000, 32'h12345678, 1'b1, 32'h00000000, 1, 0});
      vecs.push_back('{1'b0, 2'd3, 1'b1, 12'h004, 32'h00000000, 1'b1, 32'h00000000, 1, 0});
      vecs.push_back('{1'b1, 2'd1, 1'b0, 12'h020, 32'hFFFF8001, 1'b0, 32'h00000000, 2, 1});
      vecs.push_back('{1'b0, 2'd1, 1'b0, 12'h020, 32'h00000000, 1'b0, 32'hFFFF8001, 2, 0});
      vecs.push_back('{1'b0, 2'd1, 1'b1, 12'h020, 32'h00000000, 1'b0, 32'h00008001, 2, 0});
      vecs.push_back('{1'b0, 2'd0, 1'b0, 12'h021, 32'h00000000, 1'b0, 32'hFFFFFF80, 2, 0});
`ifdef MAU_MISALIGN_EN
      vecs.push_back('{1'b1, 2'd1, 1'b0, 12'h001, 32'h00001234, 1'b0, 32'h00000000, 2, 1});
      vecs.push_back('{1'b0, 2'd2, 1'b0, 12'h000, 32'h00000000, 1'b0, 32'h00123400, 2, 0});
      vecs.push_back('{1'b0, 2'd2, 1'b0, 12'h002, 32'h00000000, 1'b0, 32'h00000012, 3, 0});
`else
      vecs.push_back('{1'b1, 2'd1, 1'b0, 12'h001, 32'h00001234, 1'b1, 32'h00000000, 1, 0});
      vecs.push_back('{1'b0, 2'd2, 1'b0, 12'h000, 32'h00000000, 1'b0, 32'h00000000, 2, 0});
      vecs.push_back('{1'b0, 2'd2, 1'b0, 12'h002, 32'h00000000, 1'b1, 32'h00000000, 1, 0});
`endif

      for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
      for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;

      rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1 chk_reset("reset");
      @(negedge clk) rst_n = 1'b1;

      // Directed vector table.
      foreach (vecs[i]) begin
         model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, e, r, l, w);
         run_and_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].uns,
                       vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata,
                       vecs[i].exp_lat, vecs[i].exp_wr);
      end

      // Word-crossing load across words 4 and 5.
      model_and_run("st_w4", 1'b1, 2'd2, 1'b0, 12'h010, 32'h44332211);
      model_and_run("st_w5", 1'b1, 2'd2, 1'b0, 12'h014, 32'h88776655);
      model(1'b0, 2'd2, 1'b0, 12'h012, 32'h0, e, r, l, w);
      if (MIS) run_and_check("split_ld", 1'b0, 2'd2, 1'b0, 12'h012, 32'h0, 1'b0, 32'h66554433, 3, 0);
      else     run_and_check("split_ld", 1'b0, 2'd2, 1'b0, 12'h012, 32'h0, 1'b1, 32'h00000000, 1, 0);

      // Half store at the last byte wraps to word 0.
      model(1'b1, 2'd1, 1'b0, 12'hFFF, 32'h0000ABCD, e, r, l, w);
      if (MIS) begin
         run_and_check("wrap_st", 1'b1, 2'd1, 1'b0, 12'hFFF, 32'h0000ABCD, 1'b0, 32'h0, 3, 2);
         chk("wrap_w0_addr", 32'(wr_addr[0]), 32'd1023);
         chk("wrap_w0_sel",  32'(wr_sel[0]),  32'h8);
         chk("wrap_w0_byte", 32'(wr_data[0][31:24]), 32'hCD);
         chk("wrap_w1_addr", 32'(wr_addr[1]), 32'd0);
         chk("wrap_w1_sel",  32'(wr_sel[1]),  32'h1);
         chk("wrap_w1_byte", 32'(wr_data[1][7:0]), 32'hAB);
      end else begin
         run_and_check("wrap_st", 1'b1, 2'd1, 1'b0, 12'hFFF, 32'h0000ABCD, 1'b1, 32'h0, 1, 0);
      end
      model_and_run("wrap_ld_hi", 1'b0, 2'd0, 1'b1, 12'hFFF, 32'h0);
      model_and_run("wrap_ld_lo", 1'b0, 2'd0, 1'b1, 12'h000, 32'h0);

      // Response held while rsp_ready is low.
      model(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, e, exp_r, l, w);
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 12'h010;
      @(posedge clk); #1;
      req_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
         if (rsp_valid) seen = 1'b1;
         else begin @(posedge clk); #1; end
      end
      chk("hold_rsp_seen", 32'(seen), 32'd1);
      held = rsp_rdata;
      chk("hold_rdata_first", held, exp_r);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("hold%0d_valid", k), 32'(rsp_valid), 32'd1);
         chk($sformatf("hold%0d_rdata", k), rsp_rdata, exp_r);
         chk($sformatf("hold%0d_req_ready", k), 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk) rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_release_valid", 32'(rsp_valid), 32'd0);
      chk("hold_release_req_ready", 32'(req_ready), 32'd1);

      // Reset asserted while a store sits in ACC0.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 12'h300; req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("midrst_acc0_w_en", 32'(ram_w_en), 32'd1);
      rst_n = 1'b0;
      #1 chk_reset("midrst");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_no_write", ram[12'h300 >> 2], 32'h0);

      // Randomized traffic near address 0x100 and across the top-of-memory wrap.
      for (int i = 0; i < 200; i++) begin
         logic [11:0] a;
         logic [1:0]  sz;
         a  = (($urandom_range(0, 1) == 0) ? 12'h100 : 12'hFF0) + 12'($urandom_range(0, 31));
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         model_and_run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz,
                       1'($urandom_range(0, 1)), a, $urandom);
      end

      for (int wi = 0; wi < 16; wi++) begin
         int wa;
         wa = (wi < 8) ? (12'h100 >> 2) + wi : ((1 << AW) - 4 + (wi - 8)) % (1 << AW);
         chk($sformatf("ram_word%0d", wa), ram[wa],
             {ref_mem[4*wa+3], ref_mem[4*wa+2], ref_mem[4*wa+1], ref_mem[4*wa]});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end that issues accesses to the byte-enabled word RAM on behalf of the core pipeline. Accepts byte-addressed load/store requests over a valid/ready handshake and converts them into word-addressed RAM accesses with byte selects. Performs lane alignment, splits accesses that cross a word boundary, and returns sign- or zero-extended load data on a held response channel.

## Interface
- ADDR_WIDTH, 10, RAM word-address width; byte address width is ADDR_WIDTH+2
- clk  in  1  clock; all state updates on rising edge
- _rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present, held until accepted
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected, no RAM write performed
- ram_w_en  out  1  RAM write enable
- ram_sel  out  4  RAM byte selects
- ram_w_addr  out  ADDR_WIDTH  RAM write word address
- ram_wdata  out  32  RAM write data, lane-aligned
- ram_r_addr  out  ADDR_WIDTH  RAM read word address
- ram_rdata  in  32  RAM read data, combinational from ram_r_addr

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) latches all req_* fields. Next state is ACC0, or RESP with err for size 3 or a disallowed misaligned access.
- Offset o=addr[1:0], n=1<<size. Split when o+n>4. word0=addr[ADDR_WIDTH+1:2]; word1=word0+1, modulo 2^ADDR_WIDTH (wraps to 0).
- Byte mask m8 = ((1<<n)-1)<<o over 8 lanes. Store data d64 = {32'b0,wdata}<<(8*o).
- ACC0 drives ram_w_addr = ram_r_addr = word0. A store asserts ram_w_en with ram_sel=m8[3:0] and ram_wdata=d64[31:0]. A load captures ram_rdata into lo buffer. Next state is ACC1 if split, else RESP.
- ACC1 drives word1. A store uses sel=m8[7:4] and data d64[63:32]. A load captures into hi buffer. Next state is RESP.
- Load result = ({hi,lo}>>(8*o)) truncated to n bytes, then extended per req_unsigned. hi is 0 when not split.
- RESP: rsp_valid=1 with rdata/err stable until rsp_ready, then IDLE. req_ready=0 outside IDLE; no new request is accepted in the same cycle as response acceptance.
- ram_w_en=0 and ram_sel=0 in IDLE and RESP. RAM addresses hold their last value.

## Timing
- Reset (asynchronous): state IDLE. req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_w_en=0, ram_sel=0, RAM addresses 0, ram_wdata 0.
- Request accepted at edge N:
  - Aligned access: ACC0 in cycle N+1, rsp_valid from N+2.
  - Split access: rsp_valid from N+3.
  - Error: rsp_valid from N+1.
- With rsp_ready held high, throughput is one aligned access per 3 cycles.
- Store writes take effect at the RAM edge ending ACC0/ACC1. A load issued after a store's response sees the written data.
- Reset asserted mid-split: the ACC0 word write may already be committed and ACC1 is abandoned. No response is produced.

## Configuration
- MAU_MISALIGN_EN defined: split accesses execute via ACC1 as above.
- MAU_MISALIGN_EN undefined:
  - Any access with o%n≠0 goes to RESP with rsp_err=1 and rdata=0; no RAM write occurs.
  - ACC1 and the hi buffer are not compiled.

## Structure
- Package mau_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state encoding, and an extend function taking (value, size, unsigned).
- Sub-module mau_lane_align (combinational): takes o and size; outputs m8, d64 and extracted load data. The FSM and registers stay in mem_access_unit.

## Test plan
- Store word 0xDEADBEEF at 0x010, then load word at 0x010 -> RAM word 4 = 0xDEADBEEF with sel=4'hF; rsp_rdata=0xDEADBEEF, response 2 cycles after accept.
- Store byte 0x80 at 0x013, then load byte signed and unsigned -> sel=4'b1000; rdata 0xFFFFFF80 signed, 0x00000080 unsigned.
- With MAU_MISALIGN_EN, word 4 = 0x44332211 and word 5 = 0x88776655; load word at 0x012 -> two accesses, rdata=0x66554433, rsp_valid 3 cycles after accept.
- With MAU_MISALIGN_EN, store half 0xABCD at the last byte of the RAM -> word 1023 sel=4'b1000 byte 0xCD; word 0 (wrapped) sel=4'b0001 byte 0xAB.
- Without MAU_MISALIGN_EN, store half at 0x001; separately, size=3 at 0x000 -> both give rsp_err=1 one cycle after accept with ram_w_en never asserted.
- Hold rsp_ready low 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout. Assert _rst during ACC0 -> outputs return to reset values immediately.
